next_pc_unit: RTL and testbench

//  Next-PC generator that sits directly upstream of the program counter register.

---
 rtl/npc_pkg.sv | 15 +
 rtl/return_addr_stack.sv | 60 ++++++
 rtl/next_pc_unit.sv | 94 +++++++++
 tb/tb_next_pc_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC unit: default sizes and the next-PC source select encoding.
package npc_pkg;

    localparam int NPC_ADDR_W    = 8;
    localparam int NPC_RAS_DEPTH = 4;

    typedef enum logic [2:0] {
        NPC_SEL_SEQ  = 3'd0,
        NPC_SEL_BR   = 3'd1,
        NPC_SEL_JMP  = 3'd2,
        NPC_SEL_CALL = 3'd3,
        NPC_SEL_RET  = 3'd4
    } npc_sel_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. When it is full, a push overwrites the oldest entry.
// Overflow and underflow both set a sticky error flag that only reset clears.
module return_addr_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_top,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [PTR_W-1:0] w_top_idx;

    // r_ptr points at the next free slot, so the top entry sits one below it.
    assign w_top_idx = r_ptr - PTR_W'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CNT_W'(DEPTH));
    assign o_err     = r_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_pop) begin
            if (o_empty) begin
                r_err <= 1'b1;
            end else begin
                r_ptr <= w_top_idx;
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end else if (i_push) begin
            r_mem[r_ptr] <= i_data;
            r_ptr        <= r_ptr + PTR_W'(1);
            if (o_full) begin
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC generator with a hardware return-address stack, feeding the PC register input.
// Optional macro NPC_STALL_EN adds a stall input that holds the PC and freezes the stack.
module next_pc_unit
    import npc_pkg::*;
#(
    parameter int ADDR_W    = NPC_ADDR_W,
    parameter int RAS_DEPTH = NPC_RAS_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
`ifdef NPC_STALL_EN
    input  logic              stall,
`endif
    input  logic [ADDR_W-1:0] valorPC,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] imm,
    output logic [ADDR_W-1:0] nextPC,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_err
);

    logic              w_stall;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_br;
    logic [ADDR_W-1:0] w_top;
    npc_sel_e          w_sel;

`ifdef NPC_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // Same-width add of imm is the sign-extended offset taken modulo 2^ADDR_W.
    assign w_seq  = valorPC + ADDR_W'(1);
    assign w_br   = w_seq + imm;
    assign w_pop  = ret & ~w_stall;
    assign w_push = call & ~ret & ~w_stall;

    always_comb begin
        w_sel = NPC_SEL_SEQ;
        if (ret) begin
            if (!ras_empty) begin
                w_sel = NPC_SEL_RET;
            end
        end else if (call) begin
            w_sel = NPC_SEL_CALL;
        end else if (jump) begin
            w_sel = NPC_SEL_JMP;
        end else if (branch && zero) begin
            w_sel = NPC_SEL_BR;
        end
    end

    always_comb begin
        nextPC = w_seq;
        if (reset) begin
            nextPC = '0;
        end else if (w_stall) begin
            nextPC = valorPC;
        end else begin
            case (w_sel)
                NPC_SEL_BR:   nextPC = w_br;
                NPC_SEL_JMP:  nextPC = imm;
                NPC_SEL_CALL: nextPC = imm;
                NPC_SEL_RET:  nextPC = w_top;
                default:      nextPC = w_seq;
            endcase
        end
    end

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_seq),
        .o_top   (w_top),
        .o_empty (ras_empty),
        .o_full  (ras_full),
        .o_err   (ras_err)
    );

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: expected next-PC values go through a scoreboard queue.
// Define NPC_STALL_EN to cover the stall build as well.
module tb_next_pc_unit;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] valorPC;
    logic       branch, zero, jump, call, ret;
    logic [7:0] imm;
    logic [7:0] nextPC;
    logic       ras_empty, ras_full, ras_err;
`ifdef NPC_STALL_EN
    logic       stall = 1'b0;
`endif

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    next_pc_unit dut (
        .clock     (clock),
        .reset     (reset),
`ifdef NPC_STALL_EN
        .stall     (stall),
`endif
        .valorPC   (valorPC),
        .branch    (branch),
        .zero      (zero),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .imm       (imm),
        .nextPC    (nextPC),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_npc();
        exp_t e;
        #2;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty: observed=%0h expected=none", nextPC);
        end else begin
            e = sb.pop_front();
            assert (nextPC === e.val) else begin
                failures++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, nextPC, e.val);
            end
        end
    endtask

    // Drive one instruction away from the clock edge, check nextPC, let one edge commit it,
    // then return the controls to idle.
    task automatic step(input string tag, input logic [7:0] pc, input logic b, input logic z,
                        input logic j, input logic c, input logic r, input logic [7:0] im,
                        input logic [7:0] exp);
        @(negedge clock);
        valorPC = pc; branch = b; zero = z; jump = j; call = c; ret = r; imm = im;
        sb.push_back('{tag, exp});
        check_npc();
        @(posedge clock);
        #1;
        branch = 1'b0; zero = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        valorPC = 8'd0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        call = 1'b0; ret = 1'b0; imm = 8'd0;

        // Reset state and first sequential step
        step("rst_npc", 8'd5, 0, 0, 0, 0, 0, 8'd0, 8'd0);
        check_bit("rst_empty", ras_empty, 1'b1);
        check_bit("rst_full", ras_full, 1'b0);
        check_bit("rst_err", ras_err, 1'b0);
        reset = 1'b0;
        step("seq_after_rst", 8'd5, 0, 0, 0, 0, 0, 8'd0, 8'd6);

        // Branch taken / not taken
        step("br_taken", 8'd10, 1, 1, 0, 0, 0, 8'hFD, 8'd8);
        step("br_not_taken", 8'd10, 1, 0, 0, 0, 0, 8'hFD, 8'd11);
        step("zero_no_branch", 8'd10, 0, 1, 0, 0, 0, 8'hFD, 8'd11);

        // Jump and lower-priority requests
        step("jump", 8'h10, 0, 0, 1, 0, 0, 8'hAB, 8'hAB);
        step("jump_over_br", 8'h10, 1, 1, 1, 0, 0, 8'h40, 8'h40);
        check_bit("jump_no_push", ras_empty, 1'b1);

        // Call then return
        step("call", 8'd20, 0, 0, 0, 1, 0, 8'd100, 8'd100);
        check_bit("call_not_empty", ras_empty, 1'b0);
        step("ret", 8'd100, 0, 0, 0, 0, 1, 8'd0, 8'd21);
        check_bit("ret_empty", ras_empty, 1'b1);
        check_bit("ret_no_err", ras_err, 1'b0);

        // Overflow: five calls into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("ovf_call%0d", i), 8'(i), 0, 0, 0, 1, 0, 8'd50, 8'd50);
            if (i == 4) begin
                check_bit("full_at_4", ras_full, 1'b1);
                check_bit("no_err_at_4", ras_err, 1'b0);
            end
        end
        check_bit("ovf_err", ras_err, 1'b1);
        check_bit("ovf_full", ras_full, 1'b1);
        step("ovf_ret1", 8'd40, 0, 0, 0, 0, 1, 8'd0, 8'd6);
        check_bit("not_full_after_pop", ras_full, 1'b0);
        step("ovf_ret2", 8'd40, 0, 0, 0, 0, 1, 8'd0, 8'd5);
        step("ovf_ret3", 8'd40, 0, 0, 0, 0, 1, 8'd0, 8'd4);
        step("ovf_ret4", 8'd40, 0, 0, 0, 0, 1, 8'd0, 8'd3);
        check_bit("drained_empty", ras_empty, 1'b1);
        step("udf_ret", 8'd40, 0, 0, 0, 0, 1, 8'd0, 8'd41);
        check_bit("udf_err_sticky", ras_err, 1'b1);
        check_bit("udf_still_empty", ras_empty, 1'b1);

        // Mid-run reset clears the sticky error and forces nextPC to 0
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_bit("rst2_err", ras_err, 1'b0);
        check_bit("rst2_empty", ras_empty, 1'b1);
        step("rst2_npc", 8'h77, 0, 0, 1, 0, 0, 8'h55, 8'd0);
        reset = 1'b0;

        // Wrap-around and priority
        step("seq_wrap", 8'hFF, 0, 0, 0, 0, 0, 8'd0, 8'h00);
        step("br_wrap", 8'hFE, 1, 1, 0, 0, 0, 8'h03, 8'h02);
        step("call_pc6", 8'd6, 0, 0, 0, 1, 0, 8'h33, 8'h33);
        step("ret_call_jump", 8'h33, 0, 0, 1, 1, 1, 8'h99, 8'd7);
        check_bit("prio_no_push", ras_empty, 1'b1);
        check_bit("prio_no_err", ras_err, 1'b0);
        step("udf_after_prio", 8'h80, 0, 0, 0, 0, 1, 8'h00, 8'h81);
        check_bit("udf2_err", ras_err, 1'b1);

`ifdef NPC_STALL_EN
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        step("stl_call", 8'd3, 0, 0, 0, 1, 0, 8'd60, 8'd60);
        stall = 1'b1;
        step("stl_hold_call", 8'd30, 0, 0, 0, 1, 0, 8'd77, 8'd30);
        check_bit("stl_not_full", ras_full, 1'b0);
        check_bit("stl_not_empty", ras_empty, 1'b0);
        step("stl_hold_jump", 8'd31, 1, 1, 1, 0, 0, 8'd90, 8'd31);
        stall = 1'b0;
        step("stl_ret_top", 8'd50, 0, 0, 0, 0, 1, 8'd0, 8'd4);
        check_bit("stl_empty", ras_empty, 1'b1);
        stall = 1'b1;
        step("stl_hold_ret", 8'd52, 0, 0, 0, 0, 1, 8'd0, 8'd52);
        check_bit("stl_no_udf", ras_err, 1'b0);
        stall = 1'b0;
`endif

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_left: observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
